// File: rtl/ndp_trim_ctrl.sv
// ndp_trim_ctrl: per-channel leaky-bucket queue-depth estimator.
// Each packet is passed whole, trimmed to HDR_LEN, or dropped, based on the
// channel's registered depth and its NORMAL/TRIM hysteresis state.
// Optional feature macro: NDP_TRIM_STATS_EN adds per-channel trim/drop
// counters with a registered select/read port.
//
// Handshake: in_valid[i] is a single-cycle arrival strobe with no ready
// signal (no backpressure). Every strobe produces exactly one out_valid[i]
// pulse one cycle later, carrying the decided length and trim/drop flags.
// When out_valid[i] is low, out_len/out_trim/out_drop for that lane are 0.
module ndp_trim_ctrl #(
    parameter int N_CH      = 8,
    parameter int LEN_W     = 8,
    parameter int DEPTH_W   = 14,
    parameter int DRAIN     = 62,
    parameter int MAX_DEPTH = 12288,
    parameter int HI_THRESH = 10240,
    parameter int LO_THRESH = 8192,
    parameter int HDR_LEN   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*LEN_W-1:0]    in_len,
    output logic [N_CH-1:0]          out_valid,
    output logic [N_CH*LEN_W-1:0]    out_len,
    output logic [N_CH-1:0]          out_trim,
    output logic [N_CH-1:0]          out_drop,
    output logic [N_CH-1:0]          congested,
    output logic [N_CH*DEPTH_W-1:0]  depth_o
`ifdef NDP_TRIM_STATS_EN
    ,
    input  logic [$clog2(N_CH)-1:0]  stat_sel,
    input  logic                     stat_clr,
    output logic [31:0]              stat_trim_cnt,
    output logic [31:0]              stat_drop_cnt
`endif
);

    // One extra bit of headroom so depth + charge never wraps before clamping.
    localparam int SUM_W = DEPTH_W + 1;

    localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_DEPTH);
    localparam logic [SUM_W-1:0] DRAIN_S = SUM_W'(DRAIN);
    localparam logic [SUM_W-1:0] HDR_S   = SUM_W'(HDR_LEN);
    localparam logic [SUM_W-1:0] HI_S    = SUM_W'(HI_THRESH);
    localparam logic [SUM_W-1:0] LO_S    = SUM_W'(LO_THRESH);
    localparam logic [LEN_W-1:0] HDR_L   = LEN_W'(HDR_LEN);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_TRIM   = 1'b1
    } state_t;

    state_t             state_q [N_CH];
    state_t             state_d [N_CH];
    logic [DEPTH_W-1:0] depth_q [N_CH];
    logic [DEPTH_W-1:0] depth_d [N_CH];

    logic [N_CH-1:0]       valid_d;
    logic [N_CH-1:0]       trim_d;
    logic [N_CH-1:0]       drop_d;
    logic [N_CH*LEN_W-1:0] len_d;

    // Per-channel decision, depth update and next-state logic.
    always_comb begin : decide
        logic [SUM_W-1:0] d_ext;
        logic [SUM_W-1:0] len_ext;
        logic [SUM_W-1:0] chg;
        logic [SUM_W-1:0] t;
        logic [SUM_W-1:0] dn;
        valid_d = in_valid;
        trim_d  = '0;
        drop_d  = '0;
        len_d   = '0;
        d_ext   = '0;
        len_ext = '0;
        chg     = '0;
        t       = '0;
        dn      = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            d_ext      = SUM_W'(depth_q[i]);
            len_ext    = SUM_W'(in_len[i*LEN_W +: LEN_W]);
            chg        = '0;
            if (in_valid[i]) begin
                if ((state_q[i] == ST_NORMAL) && (d_ext + len_ext <= MAX_S)) begin
                    chg                      = len_ext;
                    len_d[i*LEN_W +: LEN_W]  = in_len[i*LEN_W +: LEN_W];
                end else if (d_ext + HDR_S <= MAX_S) begin
                    chg                      = HDR_S;
                    len_d[i*LEN_W +: LEN_W]  = HDR_L;
                    trim_d[i]                = 1'b1;
                end else begin
                    drop_d[i]                = 1'b1;
                end
            end
            // Leaky bucket: charge, then drain, floor at zero, clamp at ceiling.
            t = d_ext + chg;
            if (t < DRAIN_S) begin
                dn = '0;
            end else begin
                dn = t - DRAIN_S;
            end
            if (dn > MAX_S) begin
                dn = MAX_S;
            end
            depth_d[i] = DEPTH_W'(dn);
            // Hysteresis: threshold equality holds the current state.
            case (state_q[i])
                ST_NORMAL: if (dn > HI_S) state_d[i] = ST_TRIM;
                ST_TRIM:   if (dn < LO_S) state_d[i] = ST_NORMAL;
                default:   state_d[i] = ST_NORMAL;
            endcase
        end
    end

    // State, depth and registered packet outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_NORMAL;
                depth_q[i] <= '0;
            end
            out_valid <= '0;
            out_len   <= '0;
            out_trim  <= '0;
            out_drop  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                depth_q[i] <= depth_d[i];
            end
            out_valid <= valid_d;
            out_len   <= len_d;
            out_trim  <= trim_d;
            out_drop  <= drop_d;
        end
    end

    // Expose registered state and depth per channel.
    always_comb begin
        congested = '0;
        depth_o   = '0;
        for (int i = 0; i < N_CH; i++) begin
            congested[i]                = (state_q[i] == ST_TRIM);
            depth_o[i*DEPTH_W +: DEPTH_W] = depth_q[i];
        end
    end

`ifdef NDP_TRIM_STATS_EN
    logic [31:0] trim_cnt [N_CH];
    logic [31:0] drop_cnt [N_CH];

    // Saturating event counters; a clear in the same cycle discards increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                trim_cnt[i] <= '0;
                drop_cnt[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < N_CH; i++) begin
                trim_cnt[i] <= '0;
                drop_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (trim_d[i] && (trim_cnt[i] != 32'hFFFF_FFFF)) begin
                    trim_cnt[i] <= trim_cnt[i] + 32'd1;
                end
                if (drop_d[i] && (drop_cnt[i] != 32'hFFFF_FFFF)) begin
                    drop_cnt[i] <= drop_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Registered read of the selected channel's counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_trim_cnt <= '0;
            stat_drop_cnt <= '0;
        end else begin
            stat_trim_cnt <= trim_cnt[stat_sel];
            stat_drop_cnt <= drop_cnt[stat_sel];
        end
    end
`endif

endmodule
